// File: rtl/timer_pkg.sv
// Shared definitions for the irq_timer block: FSM encoding, register map and CTRL field layout.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   localparam int unsigned CTRL_EN       = 32'd0;
   localparam int unsigned CTRL_MODE_LSB = 32'd1;
   localparam int unsigned CTRL_IM       = 32'd3;
   localparam int unsigned CTRL_DIV_LSB  = 32'd4;

   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider for irq_timer: strobes tick once every DIV+1 run cycles.
// Only instantiated when TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  run,
   input  logic [PRESCALE_W-1:0] div,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] pcnt_r;

   assign tick = run && (pcnt_r == div);

   // prescale counter: cleared on LOAD, advances and wraps only while counting
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt_r <= '0;
      end else if (clr) begin
         pcnt_r <= '0;
      end else if (run) begin
         if (pcnt_r == div) begin
            pcnt_r <= '0;
         end else begin
            pcnt_r <= pcnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/irq_timer.sv
// Memory-mapped countdown timer driving the CPU interrupt (one-shot sticky or auto-reload pulse).
// Optional prescaler (CTRL DIV field) is enabled by defining TIMER_PRESCALE_EN.
module irq_timer
   import timer_pkg::*;
#(
   parameter int PRESCALE_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   state_t      state_r, state_nxt_s;
   logic        en_r, im_r, pending_r;
   logic [1:0]  mode_r;
   logic [31:0] preset_r, count_r, count_nxt_s;
   logic        wr_ctrl_s, wr_preset_s;
   logic        set_pend_s, clr_pend_s, clr_en_s;
   logic        ps_clr_s, ps_run_s, tick_s;
   logic [31:0] ctrl_rd_s;
   logic        unused_s;

   assign wr_ctrl_s   = we && (addr == ADDR_CTRL);
   assign wr_preset_s = we && (addr == ADDR_PRESET);
   assign irq         = im_r & pending_r;

`ifdef TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] div_r;

   timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (ps_clr_s),
      .run   (ps_run_s),
      .div   (div_r),
      .tick  (tick_s)
   );

   // DIV field of CTRL
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_r <= '0;
      end else if (wr_ctrl_s) begin
         div_r <= wdata[CTRL_DIV_LSB +: PRESCALE_W];
      end
   end

   assign unused_s = ^{wdata[31:CTRL_DIV_LSB+PRESCALE_W]};
`else
   assign tick_s   = 1'b1;
   assign unused_s = ^{wdata[31:CTRL_DIV_LSB], ps_clr_s, ps_run_s, {PRESCALE_W{1'b0}}};
`endif

   // next-state and datapath control
   always_comb begin
      state_nxt_s = state_r;
      count_nxt_s = count_r;
      set_pend_s  = 1'b0;
      clr_pend_s  = 1'b0;
      clr_en_s    = 1'b0;
      ps_clr_s    = 1'b0;
      ps_run_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (en_r) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            count_nxt_s = preset_r;
            ps_clr_s    = 1'b1;
            state_nxt_s = ST_CNT;
         end
         ST_CNT: begin
            ps_run_s = en_r;
            if (!en_r) begin
               state_nxt_s = ST_IDLE;
            end else if (!tick_s) begin
               state_nxt_s = ST_CNT;
            end else if (count_r > 32'd1) begin
               count_nxt_s = count_r - 32'd1;
            end else begin
               // 0 and 1 both terminate, so COUNT never wraps
               count_nxt_s = 32'd0;
               set_pend_s  = 1'b1;
               state_nxt_s = ST_INT;
            end
         end
         ST_INT: begin
            if (mode_r == MODE_RELOAD) begin
               clr_pend_s  = 1'b1;
               state_nxt_s = ST_LOAD;
            end else begin
               clr_en_s    = 1'b1;
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      // a new PRESET restarts the sequence from IDLE
      if (wr_preset_s && (state_r != ST_IDLE)) begin
         state_nxt_s = ST_IDLE;
      end else begin
         state_nxt_s = state_nxt_s;
      end
   end

   // FSM state and COUNT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         count_r <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         count_r <= count_nxt_s;
      end
   end

   // CTRL and PRESET registers; a bus write to CTRL outranks the one-shot EN clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_r     <= 1'b0;
         mode_r   <= MODE_ONESHOT;
         im_r     <= 1'b0;
         preset_r <= 32'd0;
      end else begin
         if (wr_ctrl_s) begin
            en_r   <= wdata[CTRL_EN];
            mode_r <= wdata[CTRL_MODE_LSB +: 2];
            im_r   <= wdata[CTRL_IM];
         end else if (clr_en_s) begin
            en_r <= 1'b0;
         end
         if (wr_preset_s) begin
            preset_r <= wdata;
         end
      end
   end

   // pending flag; register writes win over a simultaneous expiry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_r <= 1'b0;
      end else if (wr_ctrl_s || wr_preset_s) begin
         pending_r <= 1'b0;
      end else if (set_pend_s) begin
         pending_r <= 1'b1;
      end else if (clr_pend_s) begin
         pending_r <= 1'b0;
      end
   end

   // CTRL readback image
   always_comb begin
      ctrl_rd_s                            = 32'd0;
      ctrl_rd_s[CTRL_EN]                   = en_r;
      ctrl_rd_s[CTRL_MODE_LSB +: 2]        = mode_r;
      ctrl_rd_s[CTRL_IM]                   = im_r;
`ifdef TIMER_PRESCALE_EN
      ctrl_rd_s[CTRL_DIV_LSB +: PRESCALE_W] = div_r;
`endif
   end

   // register read mux
   always_comb begin
      case (addr)
         ADDR_CTRL:   rdata = ctrl_rd_s;
         ADDR_PRESET: rdata = preset_r;
         ADDR_COUNT:  rdata = count_r;
         default:     rdata = 32'd0;
      endcase
   end

endmodule
